// File: rtl/state_to_block_collector_pkg.sv
// state_to_block_collector_pkg: AES state/block geometry shared with the splitter and key schedule.
package state_to_block_collector_pkg;
   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 4;
   localparam int BLOCK_W   = WORD_W * NUM_WORDS;
   localparam int CNT_W     = 16;
   function automatic int idx_width(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/state_to_block_collector_word_index_counter.sv
// state_to_block_collector_word_index_counter: wrapping 0..N-1 index with enable and synchronous clear.
module state_to_block_collector_word_index_counter
   import state_to_block_collector_pkg::*;
#(
   parameter int N = 4,
   parameter int W = idx_width(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic         clr_i,
   output logic [W-1:0] idx_o
);
   logic [W-1:0] idx_q, idx_d;
   // Clear wins over enable so an abort never leaves a stray increment behind.
   assign idx_d = clr_i ? '0 : !en_i ? idx_q : idx_q == W'(N - 1) ? '0 : idx_q + 1'b1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) idx_q <= '0;
      else        idx_q <= idx_d;
   assign idx_o = idx_q;
endmodule

// File: rtl/state_to_block_collector.sv
// state_to_block_collector: rebuilds a block from NUM_WORDS serial state words, word0 most significant,
// with a one-block output register so the next block can be collected while the sink stalls.
module state_to_block_collector
   import state_to_block_collector_pkg::*;
#(
   parameter int WORD_W    = state_to_block_collector_pkg::WORD_W,
   parameter int NUM_WORDS = state_to_block_collector_pkg::NUM_WORDS,
   parameter int CNT_W     = state_to_block_collector_pkg::CNT_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [WORD_W-1:0]           in_word_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic                        flush_i,
   output logic [WORD_W*NUM_WORDS-1:0] out_data_o,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic                        busy_o,
   output logic [CNT_W-1:0]            block_count_o
);
   localparam int BLOCK_W = WORD_W * NUM_WORDS;
   localparam int IDX_W   = idx_width(NUM_WORDS);
   logic [IDX_W-1:0]   idx;
   logic [BLOCK_W-1:0] asm_q, asm_d, out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               last, accept, done, take;
   // Only the final word waits on the output register; earlier words keep flowing during a stall.
   assign last       = idx == IDX_W'(NUM_WORDS - 1);
   assign in_ready_o = !flush_i && (!last || !out_valid_q || out_ready_i);
   assign accept     = in_valid_i && in_ready_o;
   assign done       = accept && last;
   assign take       = out_valid_q && out_ready_i;
   state_to_block_collector_word_index_counter #(.N(NUM_WORDS), .W(IDX_W)) u_idx (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (accept),
      .clr_i (flush_i),
      .idx_o (idx)
   );
   always_comb begin
      asm_d = asm_q;
      for (int k = 0; k < NUM_WORDS; k++)
         if (accept && idx == IDX_W'(k)) asm_d[BLOCK_W-1-k*WORD_W -: WORD_W] = in_word_i;
      if (flush_i) asm_d = '0;
   end
   // asm_d already carries the final word, so a completing block loads straight into the output.
   assign out_data_d  = done ? asm_d : out_data_q;
   assign out_valid_d = done || (out_valid_q && !out_ready_i);
   assign count_d     = count_q + CNT_W'(take);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         asm_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         count_q     <= '0;
      end else begin
         asm_q       <= asm_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         count_q     <= count_d;
      end
   assign out_data_o    = out_data_q;
   assign out_valid_o   = out_valid_q;
   assign busy_o        = idx != '0;
   assign block_count_o = count_q;
endmodule

// File: tb/tb_state_to_block_collector.sv
// tb_state_to_block_collector: table-driven handshake vectors, scoreboarded random round-trip,
// asynchronous reset and block counter wrap (on a narrow-counter instance).
module tb_state_to_block_collector;
   typedef struct {
      bit          vi;
      logic [31:0] w;
      bit          fl, ordy, rdy, busy, ov;
      logic [15:0] cnt;
   } vec_t;

   logic         clk = 1'b0, rst_n = 1'b0;
   logic [31:0]  in_word = '0;
   logic         in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic         in_ready, out_valid, busy;
   logic [127:0] out_data;
   logic [15:0]  block_count;
   logic         w_valid = 1'b0, w_ready, w_ov, w_busy;
   logic [127:0] w_data;
   logic [3:0]   w_cnt;

   int           n_chk = 0, n_fail = 0, popped = 0;
   logic [127:0] sb[$];
   int           m_idx = 0;
   bit           m_ov = 1'b0;
   logic [15:0]  m_cnt = '0;
   vec_t         tab[23];

   always #5 clk = ~clk;

   state_to_block_collector dut (
      .clk(clk), .rst_n(rst_n), .in_word_i(in_word), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .flush_i(flush), .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .busy_o(busy), .block_count_o(block_count)
   );

   state_to_block_collector #(.CNT_W(4)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .in_word_i(32'h0), .in_valid_i(w_valid), .in_ready_o(w_ready),
      .flush_i(1'b0), .out_data_o(w_data), .out_valid_o(w_ov), .out_ready_i(1'b1),
      .busy_o(w_busy), .block_count_o(w_cnt)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock of stimulus: ready sampled on the falling edge, state checked just after the rising edge.
   task automatic step(input vec_t v, input bit chk, output bit acc);
      bit m_rdy, take, done;
      in_valid = v.vi; in_word = v.w; flush = v.fl; out_ready = v.ordy;
      @(negedge clk);
      m_rdy = !v.fl && (m_idx != 3 || !m_ov || v.ordy);
      check("in_ready", in_ready, chk ? v.rdy : m_rdy);
      acc  = v.vi && m_rdy;
      done = acc && m_idx == 3;
      take = m_ov && v.ordy;
      if (take) begin
         popped++;
         if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL out_unexpected: got %h expected no block", out_data);
         end else check("out_data", out_data, sb.pop_front());
      end
      @(posedge clk); #1;
      m_idx = v.fl ? 0 : acc ? (m_idx + 1) % 4 : m_idx;
      m_ov  = done || (m_ov && !v.ordy);
      m_cnt = m_cnt + 16'(take);
      check("busy", busy, chk ? v.busy : m_idx != 0);
      check("out_valid", out_valid, chk ? v.ov : m_ov);
      check("block_count", block_count, chk ? v.cnt : m_cnt);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      bit           acc;
      vec_t         v;
      logic [127:0] d;
      logic [31:0]  wq[$];
      int           sent, cyc, base;
      tab[0]  = '{1, 32'h00112233, 0, 1, 1, 1, 0, 16'd0};
      tab[1]  = '{1, 32'h44556677, 0, 1, 1, 1, 0, 16'd0};
      tab[2]  = '{1, 32'h8899AABB, 0, 1, 1, 1, 0, 16'd0};
      tab[3]  = '{1, 32'hCCDDEEFF, 0, 1, 1, 0, 1, 16'd0};
      tab[4]  = '{0, 32'h00000000, 0, 1, 1, 0, 0, 16'd1};
      tab[5]  = '{1, 32'hA0000000, 0, 0, 1, 1, 0, 16'd1};
      tab[6]  = '{1, 32'hA1111111, 0, 0, 1, 1, 0, 16'd1};
      tab[7]  = '{1, 32'hA2222222, 0, 0, 1, 1, 0, 16'd1};
      tab[8]  = '{1, 32'hA3333333, 0, 0, 1, 0, 1, 16'd1};
      tab[9]  = '{1, 32'hB0000000, 0, 0, 1, 1, 1, 16'd1};
      tab[10] = '{1, 32'hB1111111, 0, 0, 1, 1, 1, 16'd1};
      tab[11] = '{1, 32'hB2222222, 0, 0, 1, 1, 1, 16'd1};
      tab[12] = '{1, 32'hB3333333, 0, 0, 0, 1, 1, 16'd1};
      tab[13] = '{1, 32'hB3333333, 0, 1, 1, 0, 1, 16'd2};
      tab[14] = '{0, 32'h00000000, 0, 1, 1, 0, 0, 16'd3};
      tab[15] = '{1, 32'hDEAD0000, 0, 1, 1, 1, 0, 16'd3};
      tab[16] = '{1, 32'hDEAD0001, 0, 1, 1, 1, 0, 16'd3};
      tab[17] = '{1, 32'hDEAD0002, 1, 1, 0, 0, 0, 16'd3};
      tab[18] = '{1, 32'hC0000000, 0, 1, 1, 1, 0, 16'd3};
      tab[19] = '{1, 32'hC1111111, 0, 1, 1, 1, 0, 16'd3};
      tab[20] = '{1, 32'hC2222222, 0, 1, 1, 1, 0, 16'd3};
      tab[21] = '{1, 32'hC3333333, 0, 1, 1, 0, 1, 16'd3};
      tab[22] = '{0, 32'h00000000, 0, 1, 1, 0, 0, 16'd4};
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_block_count", block_count, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      sb.push_back(128'h00112233_44556677_8899AABB_CCDDEEFF);
      sb.push_back(128'hA0000000_A1111111_A2222222_A3333333);
      sb.push_back(128'hB0000000_B1111111_B2222222_B3333333);
      sb.push_back(128'hC0000000_C1111111_C2222222_C3333333);
      for (int i = 0; i < 23; i++) step(tab[i], 1'b1, acc);
      check("table_sb_drained", 128'(sb.size()), 0);

      for (int i = 0; i < 6; i++) begin
         v = '{1, 32'h5A5A0000 + 32'(i), 0, 0, 0, 0, 0, 16'd0};
         step(v, 1'b0, acc);
      end
      check("pre_rst_out_valid", out_valid, 1);
      check("pre_rst_busy", busy, 1);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_out_data", out_data, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_block_count", block_count, 0);
      check("async_rst_in_ready", in_ready, 1);
      m_idx = 0; m_ov = 1'b0; m_cnt = '0; sb.delete();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      sent = 0; cyc = 0; base = popped;
      while (popped - base < 1000 && cyc < 40000) begin
         if (wq.size() == 0 && sent < 1000) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            sb.push_back(d);
            for (int k = 0; k < 4; k++) wq.push_back(d[127-32*k -: 32]);
            sent++;
         end
         v.vi   = wq.size() > 0 && $urandom_range(0, 3) != 0;
         v.w    = v.vi ? wq[0] : $urandom;
         v.fl   = 1'b0;
         v.ordy = $urandom_range(0, 3) != 0;
         step(v, 1'b0, acc);
         if (acc) void'(wq.pop_front());
         cyc++;
      end
      check("roundtrip_blocks", 128'(popped - base), 1000);
      check("roundtrip_sb_drained", 128'(sb.size()), 0);

      w_valid = 1'b1;
      repeat (61) @(posedge clk);
      #1 check("wrap_count_max", w_cnt, 4'hF);
      repeat (4) @(posedge clk);
      #1 check("wrap_count_zero", w_cnt, 4'h0);
      w_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/state_to_block_collector.md
Name: state_to_block_collector

Overview:
Word-serial assembler that rebuilds a 128-bit AES block from four 32-bit state words. It is the inverse of the BlockTostate splitter: word0 lands in data[127:96] and word3 in data[31:0]. It sits at the output of the round datapath, ahead of the ciphertext sink. Words arrive over a valid/ready stream and complete blocks leave over a valid/ready stream. A one-block output register lets collection of the next block overlap with output backpressure.

Parameters:
WORD_W, 32, width of one state word in bits
NUM_WORDS, 4, words per block; the output width is WORD_W*NUM_WORDS
CNT_W, 16, width of the completed-block counter

Ports:
clk  input  1  single clock; all flops sample on its rising edge
rst_n  input  1  asynchronous, active-low reset; deassertion is externally synchronised to clk
in_word  input  WORD_W  state word, first word = most significant
in_valid  input  1  in_word is valid
in_ready  output  1  collector accepts in_word this cycle
flush  input  1  synchronous abort of a partially collected block
out_data  output  WORD_W*NUM_WORDS  assembled block
out_valid  output  1  out_data holds a complete block
out_ready  input  1  downstream accepts out_data this cycle
busy  output  1  partial block in progress (word index != 0)
block_count  output  CNT_W  number of blocks handed downstream; wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst_n=0): word index=0, assembly register=0, out_data=0, out_valid=0, block_count=0. Consequently in_ready=1 and busy=0 after reset.
- Input handshake: a word is accepted on any clk edge where in_valid && in_ready.
  - The word is written to slot idx, i.e. bits [BLOCK_W-1-idx*WORD_W -: WORD_W].
  - idx then increments, wrapping from NUM_WORDS-1 to 0.
- Completion: when the word accepted has idx=NUM_WORDS-1, the full block (three stored words plus in_word) is loaded directly into out_data.
  - out_valid=1 on the next cycle, so latency is 1 cycle from the last accepted word.
  - idx returns to 0.
- in_ready = !flush && (idx != NUM_WORDS-1 || !out_valid || out_ready). This is combinational from out_ready and flush.
  - Words 0..NUM_WORDS-2 are always accepted, even while the output is stalled.
  - Only the final word stalls.
- Output handshake: out_valid && out_ready clears out_valid and increments block_count.
  - If a new block completes in the same cycle, out_data reloads and out_valid stays 1. This gives back-to-back throughput of one block per NUM_WORDS cycles with no bubble.
- out_data and out_valid are stable while out_valid && !out_ready.
- flush=1:
  - Next cycle idx=0 and the assembly register is cleared.
  - Any in_word presented that cycle is not accepted (in_ready=0).
  - out_valid, out_data and block_count are unaffected.
- busy = (idx != 0).
- block_count wraps from 2^CNT_W-1 to 0 with no flag.
- rst_n asserted mid-block or with out_valid=1: everything returns to reset values and the pending data is lost.
- No internal FSM beyond the idx counter and the out_valid flag. Two states exist: COLLECTING (idx 0..NUM_WORDS-1), and an orthogonal OUT_FULL flag.

Decomposition:
- Shared package aes_pkg holds WORD_W=32, NUM_WORDS=4 and BLOCK_W=128. BlockTostate, the key schedule and this block share these constants.
- Word-index counter: a localparam-derived width of $clog2(NUM_WORDS).
- A single module is natural. The optional sub-module word_index_counter (wrapping counter with enable and synchronous clear) is reusable by a future serialiser.

Test Plan:
1. Reset, then 4 back-to-back words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with out_ready=1.
   -> out_data=0x00112233445566778899AABBCCDDEEFF with out_valid high exactly 1 cycle after word 4; block_count=1; busy=1 after words 1-3.
2. Hold out_ready=0 after block A completes, then feed block B.
   -> B words 0-2 accepted; in_ready=0 on B word 3; out_data stays at A.
   -> Raise out_ready: A handed off, B word 3 accepted in the same cycle, B appears next cycle; block_count=2.
3. After 2 words, assert flush for 1 cycle with in_valid=1.
   -> That word is dropped, busy=0, block_count unchanged.
   -> The next 4 words form a clean block with no residue from the flushed words.
4. Pull rst_n low asynchronously (between clock edges) while idx=2 and out_valid=1.
   -> out_valid=0, out_data=0, busy=0 and block_count=0 immediately, without waiting for a clk edge.
5. Round-trip: random 128-bit D into BlockTostate, word0..word3 fed serially.
   -> out_data==D for 1000 random blocks with random in_valid/out_ready gaps; no loss or duplication.
6. Preload block_count to 0xFFFF via 65535 blocks, then one more block.
   -> block_count=0x0000.
